// File: rtl/coeff_unpack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_unpack_ctrl_pkg
//  Description : Saber polynomial constants and controller state encoding
//                shared by the coefficient unpacking controller and its bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package coeff_unpack_ctrl_pkg;

    // Polynomial degree and coefficient widths (mod q and mod p)
    localparam int SABER_N      = 256;
    localparam int SABER_EQ     = 13;
    localparam int SABER_EP     = 10;

    // Packed memory word width and the resulting word count per polynomial
    localparam int SABER_WORD_W = 64;
    localparam int NWORDS_Q     = SABER_N * SABER_EQ / SABER_WORD_W;
    localparam int NWORDS_P     = SABER_N * SABER_EP / SABER_WORD_W;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/coeff_unpack_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_unpack_ctrl_if
//  Description : Bundles the command, BRAM read port and coefficient stream
//                of the unpacking controller. master = controller side,
//                slave = environment side (BRAM, sequencer, consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface coeff_unpack_ctrl_if
    import coeff_unpack_ctrl_pkg::*;
#(
    parameter int WORD_W = SABER_WORD_W,
    parameter int ADDR_W = 8
) ();

    // Command
    logic                start;
    logic                ten_bit_coeff;
    logic [ADDR_W-1:0]   base_addr;

    // BRAM read port
    logic                mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_rdata;

    // Coefficient stream
    logic [SABER_EQ-1:0] coeff_out;
    logic                coeff_valid;
    logic                coeff_ready;

    // Status
    logic                busy;
    logic                done;

    modport master (
        input  start, ten_bit_coeff, base_addr, mem_rdata, coeff_ready,
        output mem_re, mem_addr, coeff_out, coeff_valid, busy, done
    );

    modport slave (
        output start, ten_bit_coeff, base_addr, mem_rdata, coeff_ready,
        input  mem_re, mem_addr, coeff_out, coeff_valid, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/coeff_unpack_ctrl_bit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_bit_buffer
//  Description : Bit-level refill buffer of 2*WORD_W bits. The LSB holds the
//                oldest bit. A pop drops WIDTH bits from the bottom; a push
//                inserts a full word directly above the bits that remain
//                after the pop of the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module coeff_bit_buffer #(
    parameter int WORD_W = 64,
    parameter int OUT_W  = 13,
    parameter int LVL_W  = $clog2(2 * WORD_W + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              push,
    input  wire logic [WORD_W-1:0] push_data,
    input  wire logic              pop,
    input  wire logic [LVL_W-1:0]  width,
    output logic      [OUT_W-1:0]  data,
    output logic      [LVL_W-1:0]  level
);

    localparam int BUF_W = 2 * WORD_W;

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_next;
    logic [BUF_W-1:0] shifted;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_next;
    logic [LVL_W-1:0] lvl_after_pop;

    // Apply the pop first, then drop the incoming word at the new fill level.
    // The issue logic upstream keeps lvl_after_pop <= WORD_W whenever a word
    // lands, so the inserted word always fits and the level never exceeds
    // 2*WORD_W. Bits above the level are always zero, so OR-insertion is safe.
    always_comb begin
        shifted       = buf_q;
        lvl_after_pop = level_q;
        if (pop) begin
            shifted       = buf_q >> width;
            lvl_after_pop = level_q - width;
        end
        buf_next   = shifted;
        level_next = lvl_after_pop;
        if (push) begin
            buf_next   = shifted | ({{WORD_W{1'b0}}, push_data} << lvl_after_pop);
            level_next = lvl_after_pop + LVL_W'(WORD_W);
        end
    end

    // Buffer and level registers; clear empties the buffer for a new polynomial
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q   <= '0;
            level_q <= '0;
        end else if (clear) begin
            buf_q   <= '0;
            level_q <= '0;
        end else begin
            buf_q   <= buf_next;
            level_q <= level_next;
        end
    end

    assign data  = buf_q[OUT_W-1:0];
    assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/coeff_unpack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_unpack_ctrl
//  Description : Unpacks one packed Saber polynomial from a WORD_W-bit BRAM.
//                Issues word reads (one in flight), refills a bit buffer and
//                streams one 13-bit or zero-extended 10-bit coefficient per
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module coeff_unpack_ctrl
    import coeff_unpack_ctrl_pkg::*;
#(
    parameter int N_COEFF = SABER_N,
    parameter int WORD_W  = SABER_WORD_W,
    parameter int ADDR_W  = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    coeff_unpack_ctrl_if.master bus
);

    localparam int LVL_W  = $clog2(2 * WORD_W + 1);
    localparam int OCC_W  = LVL_W + 1;
    localparam int NW_Q   = N_COEFF * SABER_EQ / WORD_W;
    localparam int NW_P   = N_COEFF * SABER_EP / WORD_W;
    localparam int WCNT_W = $clog2(NW_Q + 1);
    localparam int CCNT_W = $clog2(N_COEFF + 1);

    state_t              state;
    state_t              state_next;

    logic                ten_q;
    logic [ADDR_W-1:0]   base_q;
    logic [WCNT_W-1:0]   words_issued;
    logic [CCNT_W-1:0]   coeffs_out;
    logic                inflight;

    logic [LVL_W-1:0]    level;
    logic [LVL_W-1:0]    width;
    logic [SABER_EQ-1:0] buf_data;
    logic [WCNT_W-1:0]   nwords;
    logic [OCC_W-1:0]    occupancy;

    logic                accept;
    logic                have_coeff;
    logic                pop;
    logic                last_pop;
    logic                words_left;
    logic                room;
    logic                mem_re_w;
    logic                coeff_valid_w;
    logic                busy_w;
    logic                done_w;

    assign width  = ten_q ? LVL_W'(SABER_EP) : LVL_W'(SABER_EQ);
    assign nwords = ten_q ? WCNT_W'(NW_P)    : WCNT_W'(NW_Q);

    // A coefficient straddling a word boundary stays unavailable until the
    // next word has landed, because the level is below the width until then.
    assign have_coeff = (level >= width) && (coeffs_out < CCNT_W'(N_COEFF));
    assign pop        = coeff_valid_w & bus.coeff_ready;
    assign last_pop   = pop && (coeffs_out == CCNT_W'(N_COEFF - 1));
    assign words_left = words_issued < nwords;

    // Occupancy counts the word landing this cycle and the pop of this cycle,
    // so a new read is only issued when its data is certain to fit.
    assign occupancy = OCC_W'(level)
                     + (inflight ? OCC_W'(WORD_W) : OCC_W'(0))
                     - (pop      ? OCC_W'(width)  : OCC_W'(0));
    assign room      = occupancy <= OCC_W'(WORD_W);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and controller outputs
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        mem_re_w      = 1'b0;
        coeff_valid_w = 1'b0;
        busy_w        = 1'b0;
        done_w        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_w        = 1'b1;
                coeff_valid_w = have_coeff;
                mem_re_w      = words_left && room;
                if (last_pop) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_w     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Mode and base address are captured only when a start is accepted
    always_ff @(posedge clk) begin
        if (!rst) begin
            ten_q  <= 1'b0;
            base_q <= '0;
        end else if (accept) begin
            ten_q  <= bus.ten_bit_coeff;
            base_q <= bus.base_addr;
        end
    end

    // Word/coefficient counters and the read-in-flight flag; clearing the flag
    // on reset discards read data returning in the cycle after a reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            words_issued <= '0;
            coeffs_out   <= '0;
            inflight     <= 1'b0;
        end else begin
            inflight <= mem_re_w;
            if (accept) begin
                words_issued <= '0;
                coeffs_out   <= '0;
            end else begin
                if (mem_re_w) begin
                    words_issued <= words_issued + WCNT_W'(1);
                end
                if (pop) begin
                    coeffs_out <= coeffs_out + CCNT_W'(1);
                end
            end
        end
    end

    coeff_bit_buffer #(
        .WORD_W (WORD_W),
        .OUT_W  (SABER_EQ),
        .LVL_W  (LVL_W)
    ) u_bit_buffer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .push      (inflight),
        .push_data (bus.mem_rdata),
        .pop       (pop),
        .width     (width),
        .data      (buf_data),
        .level     (level)
    );

    assign bus.mem_re      = mem_re_w;
    assign bus.mem_addr    = base_q + ADDR_W'(words_issued);
    assign bus.coeff_valid = coeff_valid_w;
    assign bus.coeff_out   = ten_q ? SABER_EQ'(buf_data[SABER_EP-1:0]) : buf_data;
    assign bus.busy        = busy_w;
    assign bus.done        = done_w;

endmodule
`default_nettype wire

// File: tb/tb_coeff_unpack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coeff_unpack_ctrl
//  Description : Self-checking bench for coeff_unpack_ctrl with a BRAM model
//                and a scoreboard of expected coefficients and read addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coeff_unpack_ctrl;
    import coeff_unpack_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    coeff_unpack_ctrl_if #(.WORD_W(64), .ADDR_W(8)) bus ();

    coeff_unpack_ctrl #(
        .N_COEFF (256),
        .WORD_W  (64),
        .ADDR_W  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // BRAM model: data valid exactly one cycle after the read enable
    logic [63:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_q  [$];
    logic [7:0]  addr_q [$];
    logic [12:0] obs    [0:255];
    int          hs;
    int          reads;
    int          dones;
    logic        rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Reference: coefficient k is packed bits [k*W+W-1 : k*W] of the word stream
    function automatic logic [12:0] model_coeff(input logic [7:0] base, input logic ten, input int k);
        int          w;
        logic [12:0] c;
        logic [63:0] wd;
        int          p;
        w = ten ? 10 : 13;
        c = '0;
        for (int b = 0; b < w; b++) begin
            p    = k * w + b;
            wd   = mem[8'(int'(base) + p / 64)];
            c[b] = wd[p % 64];
        end
        return c;
    endfunction

    // Scoreboard side: runs just before each rising edge
    task automatic monitor();
        logic [8:0]  ea;
        logic [13:0] ec;
        if (bus.mem_re) begin
            reads++;
            if (addr_q.size() != 0) ea = {1'b0, addr_q.pop_front()};
            else                    ea = 9'h100;
            chk("mem_addr", {1'b0, bus.mem_addr}, ea);
        end
        if (bus.coeff_valid && bus.coeff_ready) begin
            if (exp_q.size() != 0) ec = {1'b0, exp_q.pop_front()};
            else                   ec = 14'h2000;
            chk("coeff", {1'b0, bus.coeff_out}, ec);
            if (hs < 256) obs[hs] = bus.coeff_out;
            hs++;
        end
        if (bus.done) dones++;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_ready) bus.coeff_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_run(input logic [7:0] base, input logic ten);
        int nw;
        nw = ten ? NWORDS_P : NWORDS_Q;
        for (int k = 0; k < 256; k++) exp_q.push_back(model_coeff(base, ten, k));
        for (int w = 0; w < nw; w++) addr_q.push_back(8'(int'(base) + w));
        hs    = 0;
        reads = 0;
        dones = 0;
        bus.start         = 1'b1;
        bus.base_addr     = base;
        bus.ten_bit_coeff = ten;
        step();
        bus.start = 1'b0;
    endtask

    // Stops while done is high (DONE state), or after the budget expires
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            step();
            n++;
        end
        chk("done_reached", bus.done, 1'b1);
    endtask

    initial begin
        logic [12:0] held_c;
        logic        held_v;
        int          rd0;
        int          n;

        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        bus.mem_rdata     = '0;
        rst               = 1'b0;
        bus.start         = 1'b0;
        bus.ten_bit_coeff = 1'b0;
        bus.base_addr     = '0;
        bus.coeff_ready   = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_mem_re",   bus.mem_re,      1'b0);
        chk("rst_mem_addr", bus.mem_addr,    8'h00);
        chk("rst_valid",    bus.coeff_valid, 1'b0);
        chk("rst_coeff",    bus.coeff_out,   13'h0);
        chk("rst_busy",     bus.busy,        1'b0);
        chk("rst_done",     bus.done,        1'b0);
        rst = 1'b1;
        step();

        // A: 13-bit, ready=1, known pattern across the word boundary
        mem[8'h10] = 64'hFFF0_0000_0000_0000;
        mem[8'h11] = 64'h1;
        bus.coeff_ready = 1'b1;
        start_run(8'h10, 1'b0);
        chk("A_first_re",   bus.mem_re,      1'b1);
        chk("A_first_addr", bus.mem_addr,    8'h10);
        chk("A_busy",       bus.busy,        1'b1);
        chk("A_valid_lat0", bus.coeff_valid, 1'b0);
        step();
        chk("A_valid_lat1", bus.coeff_valid, 1'b0);
        step();
        chk("A_valid_lat2", bus.coeff_valid, 1'b1);
        wait_done(2000);
        // start during DONE must be ignored
        bus.start         = 1'b1;
        bus.base_addr     = 8'h80;
        bus.ten_bit_coeff = 1'b1;
        step();
        bus.start = 1'b0;
        chk("A_busy_after",  bus.busy,   1'b0);
        chk("A_no_restart",  bus.mem_re, 1'b0);
        step();
        chk("A_done_once",   dones, 1);
        chk("A_handshakes",  hs,    256);
        chk("A_reads",       reads, NWORDS_Q);
        chk("A_coeff0",      obs[0], 13'h0000);
        chk("A_coeff3",      obs[3], 13'h0000);
        chk("A_coeff4",      obs[4], 13'h1FFF);
        chk("A_sb_empty",    exp_q.size(), 0);

        // B: 10-bit, random ready
        mem[8'h80] = 64'h3FF;
        rand_ready = 1'b1;
        start_run(8'h80, 1'b1);
        step();
        step();
        wait_done(4000);
        rand_ready      = 1'b0;
        bus.coeff_ready = 1'b1;
        step();
        chk("B_handshakes", hs,    256);
        chk("B_reads",      reads, NWORDS_P);
        chk("B_done_once",  dones, 1);
        chk("B_coeff0",     obs[0], 13'h03FF);
        chk("B_coeff6",     obs[6], {3'b000, mem[8'h81][5:0], mem[8'h80][63:60]});
        chk("B_busy_after", bus.busy, 1'b0);

        // C: consumer stalls for 20 cycles mid-run
        start_run(8'h30, 1'b0);
        n = 0;
        while (hs < 30 && n < 200) begin step(); n++; end
        bus.coeff_ready = 1'b0;
        repeat (3) step();
        held_c = bus.coeff_out;
        held_v = bus.coeff_valid;
        chk("C_valid_in_stall", held_v, 1'b1);
        rd0 = reads;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("C_hold_valid", bus.coeff_valid, held_v);
            chk("C_hold_coeff", bus.coeff_out,   held_c);
            if (i == 4) rd0 = reads;
        end
        chk("C_reads_stopped", reads - rd0, 0);
        chk("C_re_low",        bus.mem_re,  1'b0);
        bus.coeff_ready = 1'b1;
        wait_done(2000);
        step();
        chk("C_handshakes", hs,    256);
        chk("C_reads",      reads, NWORDS_Q);

        // D: reset after coefficient 100, then restart from base_addr
        start_run(8'h40, 1'b0);
        n = 0;
        while (hs < 101 && n < 400) begin step(); n++; end
        chk("D_reached_100", hs, 101);
        rst             = 1'b0;
        bus.coeff_ready = 1'b0;
        step();
        chk("D_rst_mem_re", bus.mem_re,      1'b0);
        chk("D_rst_addr",   bus.mem_addr,    8'h00);
        chk("D_rst_valid",  bus.coeff_valid, 1'b0);
        chk("D_rst_coeff",  bus.coeff_out,   13'h0);
        chk("D_rst_busy",   bus.busy,        1'b0);
        chk("D_rst_done",   bus.done,        1'b0);
        step();
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        step();
        bus.coeff_ready = 1'b1;
        start_run(8'h40, 1'b0);
        chk("D_restart_addr", bus.mem_addr, 8'h40);
        wait_done(2000);
        step();
        chk("D_handshakes", hs,    256);
        chk("D_reads",      reads, NWORDS_Q);

        // E: start while busy with another base/mode is ignored
        start_run(8'h80, 1'b1);
        repeat (20) step();
        bus.start         = 1'b1;
        bus.base_addr     = 8'h10;
        bus.ten_bit_coeff = 1'b0;
        step();
        bus.start = 1'b0;
        wait_done(2000);
        step();
        chk("E_handshakes", hs,    256);
        chk("E_reads",      reads, NWORDS_P);
        chk("E_sb_empty",   exp_q.size() + addr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
